// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks X/M/W producers, detects load-use or interlock hazards,
// steers X-stage operand bypass muxes and counts hazard-stall cycles.
module hazard_unit #(
  parameter int REG_BITS   = 5,
  parameter int FORWARD_EN = 1,
  parameter int RF_BYPASS  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                d_valid,
  input  logic [REG_BITS-1:0] d_src_1,
  input  logic [REG_BITS-1:0] d_src_2,
  input  logic                d_use_1,
  input  logic                d_use_2,
  input  logic [REG_BITS-1:0] d_dst,
  input  logic                d_reg_write,
  input  logic                d_mem_read,
  input  logic                ext_stall,
  input  logic                x_redirect,
  output logic                f_stall,
  output logic                d_stall,
  output logic                f_flush,
  output logic                d_flush,
  output logic [1:0]          fwd_sel_1,
  output logic [1:0]          fwd_sel_2,
  output logic [1:0]          inflight,
  output logic [CNT_W-1:0]    hazard_cnt
);

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] dst;
    logic                reg_write;
    logic                mem_read;
    logic [REG_BITS-1:0] src_1;
    logic [REG_BITS-1:0] src_2;
    logic                use_1;
    logic                use_2;
  } entry_t;

  localparam entry_t BUBBLE = entry_t'({$bits(entry_t){1'b0}});

  entry_t           x_r, m_r, w_r, x_new_s;
  logic             hit_x_s, hit_m_s, hit_w_s, hazard_s, advance_s;
  logic [CNT_W-1:0] cnt_r;

  // Register 0 is hard-wired zero, so it never produces a dependency.
  function automatic logic src_match(input logic use_bit, input logic [REG_BITS-1:0] src,
                                     input entry_t e);
    return use_bit & e.valid & e.reg_write & (e.dst == src) & (src != {REG_BITS{1'b0}});
  endfunction

  function automatic logic [1:0] fwd_pick(input logic use_bit, input logic [REG_BITS-1:0] src,
                                          input entry_t m_e, input entry_t w_e);
    logic [1:0] sel;
    if (src_match(use_bit, src, m_e)) begin
      sel = 2'b01;
    end else if (src_match(use_bit, src, w_e)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection against the tracked producers.
  always_comb begin
    hit_x_s = src_match(d_use_1, d_src_1, x_r) | src_match(d_use_2, d_src_2, x_r);
    hit_m_s = src_match(d_use_1, d_src_1, m_r) | src_match(d_use_2, d_src_2, m_r);
    hit_w_s = src_match(d_use_1, d_src_1, w_r) | src_match(d_use_2, d_src_2, w_r);
    if (FORWARD_EN != 0) begin
      hazard_s = d_valid & hit_x_s & x_r.mem_read;
    end else if (RF_BYPASS != 0) begin
      hazard_s = d_valid & (hit_x_s | hit_m_s);
    end else begin
      hazard_s = d_valid & (hit_x_s | hit_m_s | hit_w_s);
    end
  end

  assign advance_s = ~ext_stall;
  assign f_stall   = ext_stall | (hazard_s & ~x_redirect);
  assign d_stall   = f_stall;
  assign f_flush   = x_redirect & ~ext_stall;
  assign d_flush   = (hazard_s | x_redirect) & ~ext_stall;
  assign inflight  = {1'b0, x_r.valid} + {1'b0, m_r.valid} + {1'b0, w_r.valid};
  assign hazard_cnt = cnt_r;

  // Operand bypass select for the instruction currently in X.
  always_comb begin
    if (FORWARD_EN != 0) begin
      fwd_sel_1 = fwd_pick(x_r.use_1, x_r.src_1, m_r, w_r);
      fwd_sel_2 = fwd_pick(x_r.use_2, x_r.src_2, m_r, w_r);
    end else begin
      fwd_sel_1 = 2'b00;
      fwd_sel_2 = 2'b00;
    end
  end

  // Entry entering X: decode fields when issuing, otherwise an all-zero bubble.
  always_comb begin
    x_new_s = BUBBLE;
    if (d_valid & ~hazard_s & ~x_redirect) begin
      x_new_s.valid     = 1'b1;
      x_new_s.dst       = d_dst;
      x_new_s.reg_write = d_reg_write;
      x_new_s.mem_read  = d_mem_read;
      x_new_s.src_1     = d_src_1;
      x_new_s.src_2     = d_src_2;
      x_new_s.use_1     = d_use_1;
      x_new_s.use_2     = d_use_2;
    end else begin
      x_new_s = BUBBLE;
    end
  end

  // Tracking pipe: shifts X->M->W when not externally stalled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_r <= BUBBLE;
      m_r <= BUBBLE;
      w_r <= BUBBLE;
    end else if (advance_s) begin
      x_r <= x_new_s;
      m_r <= x_r;
      w_r <= m_r;
    end else begin
      x_r <= x_r;
      m_r <= m_r;
      w_r <= w_r;
    end
  end

  // Saturating count of cycles lost to genuine hazard stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (hazard_s & advance_s & ~x_redirect & (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus a randomized run against a
// stage-distance reference model, over three parameterizations sharing one input stream.
module tb_hazard_unit;
  logic       clock, reset;
  logic       d_valid, d_use_1, d_use_2, d_reg_write, d_mem_read, ext_stall, x_redirect;
  logic [4:0] d_src_1, d_src_2, d_dst;
  logic       fs [3], ds [3], ff [3], df [3];
  logic [1:0] f1 [3], f2 [3], inf [3];
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;
  int n_cmp = 0, n_err = 0;

  // config 0: forwarding; 1: interlock with write-through RF; 2: interlock, no RF bypass, 2-bit counter
  int cfg_fe [3] = '{1, 0, 0};
  int cfg_rb [3] = '{1, 1, 0};
  int cfg_max [3] = '{65535, 65535, 3};

  hazard_unit #(.REG_BITS(5), .FORWARD_EN(1), .RF_BYPASS(1), .CNT_W(16)) u0 (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_src_1(d_src_1), .d_src_2(d_src_2),
    .d_use_1(d_use_1), .d_use_2(d_use_2), .d_dst(d_dst), .d_reg_write(d_reg_write),
    .d_mem_read(d_mem_read), .ext_stall(ext_stall), .x_redirect(x_redirect),
    .f_stall(fs[0]), .d_stall(ds[0]), .f_flush(ff[0]), .d_flush(df[0]),
    .fwd_sel_1(f1[0]), .fwd_sel_2(f2[0]), .inflight(inf[0]), .hazard_cnt(cnt0));
  hazard_unit #(.REG_BITS(5), .FORWARD_EN(0), .RF_BYPASS(1), .CNT_W(16)) u1 (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_src_1(d_src_1), .d_src_2(d_src_2),
    .d_use_1(d_use_1), .d_use_2(d_use_2), .d_dst(d_dst), .d_reg_write(d_reg_write),
    .d_mem_read(d_mem_read), .ext_stall(ext_stall), .x_redirect(x_redirect),
    .f_stall(fs[1]), .d_stall(ds[1]), .f_flush(ff[1]), .d_flush(df[1]),
    .fwd_sel_1(f1[1]), .fwd_sel_2(f2[1]), .inflight(inf[1]), .hazard_cnt(cnt1));
  hazard_unit #(.REG_BITS(5), .FORWARD_EN(0), .RF_BYPASS(0), .CNT_W(2)) u2 (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_src_1(d_src_1), .d_src_2(d_src_2),
    .d_use_1(d_use_1), .d_use_2(d_use_2), .d_dst(d_dst), .d_reg_write(d_reg_write),
    .d_mem_read(d_mem_read), .ext_stall(ext_stall), .x_redirect(x_redirect),
    .f_stall(fs[2]), .d_stall(ds[2]), .f_flush(ff[2]), .d_flush(df[2]),
    .fwd_sel_1(f1[2]), .fwd_sel_2(f2[2]), .inflight(inf[2]), .hazard_cnt(cnt2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic v, input int s1, input int s2, input logic u1, input logic u2,
                        input int dst, input logic rw, input logic mr);
    d_valid = v; d_src_1 = 5'(s1); d_src_2 = 5'(s2); d_use_1 = u1; d_use_2 = u2;
    d_dst = 5'(dst); d_reg_write = rw; d_mem_read = mr;
  endtask

  task automatic do_reset();
    set_in(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    ext_stall = 1'b0; x_redirect = 1'b0;
    reset = 1'b0;
    #3;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_in(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    ext_stall = 1'b0; x_redirect = 1'b0;
    #1;
    n_cmp++;
    if ({fs[0], ds[0], ff[0], df[0], f1[0], f2[0], inf[0]} !== 10'b0 || cnt0 !== 16'd0) begin
      n_err++; $display("FAIL reset_idle got %b/%0d exp 0/0", {fs[0], ds[0], ff[0], df[0], f1[0], f2[0], inf[0]}, cnt0);
    end
    ext_stall = 1'b1; #1;
    n_cmp++;
    if ({fs[0], ds[0], ff[0], df[0]} !== 4'b1100) begin
      n_err++; $display("FAIL reset_ext_stall got %b exp 1100", {fs[0], ds[0], ff[0], df[0]});
    end
    ext_stall = 1'b0; x_redirect = 1'b1; #1;
    n_cmp++;
    if ({fs[0], ds[0], ff[0], df[0]} !== 4'b0011) begin
      n_err++; $display("FAIL reset_redirect got %b exp 0011", {fs[0], ds[0], ff[0], df[0]});
    end
    x_redirect = 1'b0;
    set_in(1'b1, 0, 0, 1'b0, 1'b0, 7, 1'b1, 1'b0);
    tick(); tick();
    n_cmp++;
    if (inf[0] !== 2'd0) begin
      n_err++; $display("FAIL reset_held_clocked got %0d exp 0", inf[0]);
    end
    set_in(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    n_cmp++;
    if (inf[0] !== 2'd0 || cnt0 !== 16'd0 || f1[0] !== 2'b00) begin
      n_err++; $display("FAIL reset_release got inf=%0d cnt=%0d exp 0/0", inf[0], cnt0);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(1'b1, 0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b1); #1;
    n_cmp++;
    if (ds[0] !== 1'b0) begin n_err++; $display("FAIL lu_load_issue got %b exp 0", ds[0]); end
    tick();
    set_in(1'b1, 3, 5, 1'b1, 1'b1, 4, 1'b1, 1'b0); #1;
    n_cmp++;
    if ({fs[0], ds[0], df[0], ff[0]} !== 4'b1110) begin
      n_err++; $display("FAIL lu_stall got %b exp 1110", {fs[0], ds[0], df[0], ff[0]});
    end
    tick(); #1;
    n_cmp++;
    if ({ds[0], df[0]} !== 2'b00) begin n_err++; $display("FAIL lu_one_cycle got %b exp 00", {ds[0], df[0]}); end
    tick();
    set_in(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0); #1;
    n_cmp++;
    if (f1[0] !== 2'b10 || f2[0] !== 2'b00 || cnt0 !== 16'd1) begin
      n_err++; $display("FAIL lu_forward got f1=%b f2=%b cnt=%0d exp 10/00/1", f1[0], f2[0], cnt0);
    end
  endtask

  task automatic test_alu_b2b();
    do_reset();
    set_in(1'b1, 0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b0); tick();
    set_in(1'b1, 3, 3, 1'b1, 1'b1, 6, 1'b1, 1'b0); #1;
    n_cmp++;
    if (ds[0] !== 1'b0) begin n_err++; $display("FAIL alu_no_stall got %b exp 0", ds[0]); end
    tick();
    set_in(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1); #1;
    n_cmp++;
    if (f1[0] !== 2'b01 || f2[0] !== 2'b01) begin
      n_err++; $display("FAIL alu_fwd_m got %b/%b exp 01/01", f1[0], f2[0]);
    end
    tick();
    set_in(1'b1, 0, 0, 1'b1, 1'b1, 7, 1'b1, 1'b0); #1;
    n_cmp++;
    if (ds[0] !== 1'b0) begin n_err++; $display("FAIL r0_no_stall got %b exp 0", ds[0]); end
    tick();
    set_in(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0); #1;
    n_cmp++;
    if (f1[0] !== 2'b00 || f2[0] !== 2'b00 || cnt0 !== 16'd0) begin
      n_err++; $display("FAIL r0_no_fwd got %b/%b cnt=%0d exp 00/00/0", f1[0], f2[0], cnt0);
    end
  endtask

  task automatic test_interlock();
    int st1, st2;
    st1 = 0; st2 = 0;
    do_reset();
    set_in(1'b1, 0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b0); tick();
    set_in(1'b1, 3, 0, 1'b1, 1'b0, 4, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ds[1]) st1++;
      if (ds[2]) st2++;
      n_cmp++;
      if (f1[1] !== 2'b00 || f1[2] !== 2'b00) begin
        n_err++; $display("FAIL il_fwd cyc%0d got %b/%b exp 00/00", i, f1[1], f1[2]);
      end
      tick();
    end
    n_cmp++;
    if (st1 != 2 || st2 != 3) begin
      n_err++; $display("FAIL il_stall_cycles got %0d/%0d exp 2/3", st1, st2);
    end
    n_cmp++;
    if (cnt1 !== 16'd2 || cnt2 !== 2'd3) begin
      n_err++; $display("FAIL il_cnt got %0d/%0d exp 2/3", cnt1, cnt2);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    set_in(1'b1, 3, 0, 1'b1, 1'b0, 3, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    set_in(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0); #1;
    n_cmp++;
    if (cnt1 !== 16'd6 || cnt2 !== 2'd3) begin
      n_err++; $display("FAIL sat_cnt got %0d/%0d exp 6/3", cnt1, cnt2);
    end
  endtask

  task automatic test_redirect_in_stall();
    do_reset();
    set_in(1'b1, 0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b1); tick();
    set_in(1'b1, 3, 5, 1'b1, 1'b1, 4, 1'b1, 1'b0);
    x_redirect = 1'b1; #1;
    n_cmp++;
    if ({fs[0], ds[0], ff[0], df[0]} !== 4'b0011) begin
      n_err++; $display("FAIL redir_outputs got %b exp 0011", {fs[0], ds[0], ff[0], df[0]});
    end
    tick();
    x_redirect = 1'b0;
    set_in(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0); #1;
    n_cmp++;
    if (inf[0] !== 2'd1 || cnt0 !== 16'd0) begin
      n_err++; $display("FAIL redir_bubble got inf=%0d cnt=%0d exp 1/0", inf[0], cnt0);
    end
  endtask

  task automatic test_ext_stall();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b1, 0, 0, 1'b0, 1'b0, i, 1'b1, 1'b0); tick();
    end
    set_in(1'b1, 1, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0);
    ext_stall = 1'b1; x_redirect = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({fs[0], ff[0], df[0]} !== 3'b100 || inf[0] !== 2'd3) begin
        n_err++; $display("FAIL es_frozen cyc%0d got %b inf=%0d exp 100/3", i, {fs[0], ff[0], df[0]}, inf[0]);
      end
      tick();
    end
    ext_stall = 1'b0; #1;
    n_cmp++;
    if ({fs[0], ff[0], df[0]} !== 3'b011) begin
      n_err++; $display("FAIL es_release got %b exp 011", {fs[0], ff[0], df[0]});
    end
    tick();
    x_redirect = 1'b0;
    set_in(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0); #1;
    n_cmp++;
    if (ff[0] !== 1'b0 || inf[0] !== 2'd2) begin
      n_err++; $display("FAIL es_after got ff=%b inf=%0d exp 0/2", ff[0], inf[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, 0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b1); tick();
      set_in(1'b1, 3, 0, 1'b1, 1'b0, 4, 1'b1, 1'b0); tick(); tick();
    end
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b1, 0, 0, 1'b0, 1'b0, 10 + i, 1'b1, 1'b0); tick();
    end
    ext_stall = 1'b1; #1;
    n_cmp++;
    if (inf[0] !== 2'd3 || cnt0 !== 16'd7) begin
      n_err++; $display("FAIL mid_pre got inf=%0d cnt=%0d exp 3/7", inf[0], cnt0);
    end
    reset = 1'b0; #1;
    n_cmp++;
    if (inf[0] !== 2'd0 || cnt0 !== 16'd0) begin
      n_err++; $display("FAIL mid_async got inf=%0d cnt=%0d exp 0/0", inf[0], cnt0);
    end
    ext_stall = 1'b0; reset = 1'b1;
  endtask

  // Reference model: tracked producers per config, stage 0 = X, 1 = M, 2 = W.
  int pv[3][3], pd[3][3], prw[3][3], pmr[3][3], ps1[3][3], ps2[3][3], pu1[3][3], pu2[3][3];
  int pcnt[3];

  function automatic bit writes(int c, int k, int src);
    return pv[c][k] != 0 && prw[c][k] != 0 && pd[c][k] == src && src != 0;
  endfunction

  function automatic int fwd_of(int c, int u, int s);
    if (cfg_fe[c] == 0 || u == 0) return 0;
    if (writes(c, 1, s)) return 1;
    if (writes(c, 2, s)) return 2;
    return 0;
  endfunction

  task automatic test_random();
    int srcs[2], uses[2];
    int hz, e_stall, e_ff, e_df, e_inf, got_cnt;
    logic [10:0] got, exp_v;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      pcnt[c] = 0;
      for (int k = 0; k < 3; k++) begin
        pv[c][k] = 0; pd[c][k] = 0; prw[c][k] = 0; pmr[c][k] = 0;
        ps1[c][k] = 0; ps2[c][k] = 0; pu1[c][k] = 0; pu2[c][k] = 0;
      end
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      set_in(1'($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 2) == 0));
      ext_stall = 1'($urandom_range(0, 6) == 0);
      x_redirect = 1'($urandom_range(0, 9) == 0);
      #1;
      srcs[0] = int'(d_src_1); srcs[1] = int'(d_src_2);
      uses[0] = int'(d_use_1); uses[1] = int'(d_use_2);
      for (int c = 0; c < 3; c++) begin
        // A producer blocks when it is closer than the config's bypass reach allows.
        hz = 0;
        for (int n = 0; n < 2; n++)
          for (int k = 0; k < 3; k++)
            if (d_valid && uses[n] != 0 && writes(c, k, srcs[n]) &&
                (cfg_fe[c] != 0 ? (k == 0 && pmr[c][0] != 0) : (k < 2 || cfg_rb[c] == 0)))
              hz = 1;
        e_stall = (ext_stall || (hz != 0 && !x_redirect)) ? 1 : 0;
        e_ff = (x_redirect && !ext_stall) ? 1 : 0;
        e_df = ((hz != 0 || x_redirect) && !ext_stall) ? 1 : 0;
        e_inf = pv[c][0] + pv[c][1] + pv[c][2];
        exp_v = {1'(e_stall), 1'(e_stall), 1'(e_ff), 1'(e_df),
                 2'(fwd_of(c, pu1[c][0], ps1[c][0])), 2'(fwd_of(c, pu2[c][0], ps2[c][0])), 2'(e_inf)};
        got = {fs[c], ds[c], ff[c], df[c], f1[c], f2[c], inf[c]};
        got_cnt = (c == 0) ? int'(cnt0) : (c == 1) ? int'(cnt1) : int'(cnt2);
        n_cmp++;
        if (got !== exp_v) begin
          n_err++; $display("FAIL rnd_outputs cfg%0d cyc%0d got %b exp %b", c, cyc, got, exp_v);
        end
        n_cmp++;
        if (got_cnt != pcnt[c]) begin
          n_err++; $display("FAIL rnd_cnt cfg%0d cyc%0d got %0d exp %0d", c, cyc, got_cnt, pcnt[c]);
        end
        if (!ext_stall) begin
          if (hz != 0 && !x_redirect && pcnt[c] < cfg_max[c]) pcnt[c]++;
          for (int k = 2; k > 0; k--) begin
            pv[c][k] = pv[c][k-1]; pd[c][k] = pd[c][k-1]; prw[c][k] = prw[c][k-1];
            pmr[c][k] = pmr[c][k-1]; ps1[c][k] = ps1[c][k-1]; ps2[c][k] = ps2[c][k-1];
            pu1[c][k] = pu1[c][k-1]; pu2[c][k] = pu2[c][k-1];
          end
          if (d_valid && hz == 0 && !x_redirect) begin
            pv[c][0] = 1; pd[c][0] = int'(d_dst); prw[c][0] = int'(d_reg_write);
            pmr[c][0] = int'(d_mem_read); ps1[c][0] = srcs[0]; ps2[c][0] = srcs[1];
            pu1[c][0] = uses[0]; pu2[c][0] = uses[1];
          end else begin
            pv[c][0] = 0; pd[c][0] = 0; prw[c][0] = 0; pmr[c][0] = 0;
            ps1[c][0] = 0; ps2[c][0] = 0; pu1[c][0] = 0; pu2[c][0] = 0;
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_b2b();
    test_interlock();
    test_saturate();
    test_redirect_in_stall();
    test_ext_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REG_BITS, default 5, register-index width (2**REG_BITS architectural registers, register 0 hard-wired zero).
REQ-002 SHALL have parameter FORWARD_EN, default 1, 1 = bypass from M/W, 0 = interlock-only mode.
REQ-003 SHALL have parameter RF_BYPASS, default 1, 1 = register file is write-through so a W-stage producer never stalls.
REQ-004 SHALL have parameter CNT_W, default 16, width of the hazard-stall counter.
REQ-005 clock  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 d_valid  in  1  valid instruction in decode.
REQ-008 d_src_1, d_src_2  in  REG_BITS  decode source registers.
REQ-009 d_use_1, d_use_2  in  1  source actually read.
REQ-010 d_dst  in  REG_BITS  decode destination register.
REQ-011 d_reg_write, d_mem_read  in  1  decode writes register / is load.
REQ-012 ext_stall  in  1  memory-system stall (imem or dmem).
REQ-013 x_redirect  in  1  taken branch/jump resolved in execute.
REQ-014 f_stall, d_stall  out  1  hold PC / F->D register.
REQ-015 f_flush  out  1  load bubble into F->D.
REQ-016 d_flush  out  1  load bubble into D->X.
REQ-017 fwd_sel_1, fwd_sel_2  out  2  X-stage operand source: 00 regfile, 01 M-stage ALU result, 10 W-stage write data.
REQ-018 inflight  out  2  count of valid tracked entries (X, M, W).
REQ-019 hazard_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-020 SHALL keep a 3-entry tracking pipe X, M, W; each entry holds valid, dst, reg_write, mem_read, src_1, src_2, use_1, use_2.
REQ-021 Pipe SHALL shift X->M->W (W discarded) on each edge with ext_stall=0, and hold all entries when ext_stall=1.
REQ-022 A source SHALL match an entry only when use_n=1, entry valid, reg_write=1, dst==src, and src!=0.
REQ-023 FORWARD_EN=1: hazard SHALL be 1 when d_valid and any used source matches X with X.mem_read=1 (load-use).
REQ-024 FORWARD_EN=0: hazard SHALL be 1 when d_valid and any used source matches X or M, or W when RF_BYPASS=0.
REQ-025 Outputs SHALL be combinational: f_stall=d_stall=ext_stall|(hazard&~x_redirect); f_flush=x_redirect&~ext_stall; d_flush=(hazard|x_redirect)&~ext_stall.
REQ-026 New X entry on an advancing edge SHALL be the decode fields with valid=d_valid&~hazard&~x_redirect; otherwise a bubble (valid=0).
REQ-027 x_redirect SHALL take priority over hazard; ext_stall SHALL take priority over both (no flush while stalled; source holds x_redirect).
REQ-028 fwd_sel_n SHALL be 01 if X.src_n matches M, else 10 if it matches W, else 00; M wins when both match; forced 00 when FORWARD_EN=0.
REQ-029 inflight SHALL equal X.valid+M.valid+W.valid.
REQ-030 hazard_cnt SHALL increment on each edge with hazard=1, ext_stall=0, x_redirect=0, saturating at 2**CNT_W-1.

Reset
REQ-031 reset=0 SHALL immediately clear all entries' valid and hazard_cnt, regardless of clock, including mid-stall.
REQ-032 During and after reset until first d_valid, outputs SHALL be: stalls 0 (unless ext_stall), flushes 0 (unless x_redirect), fwd_sel 00, inflight 0, hazard_cnt 0.

Verification
REQ-033 Load-use: ld r3 then add r4,r3,r5 (FORWARD_EN=1) -> d_stall=1 and d_flush=1 for exactly 1 cycle, then add issues with fwd_sel_1=10; hazard_cnt=1.
REQ-034 ALU back-to-back: add r3 then sub r6,r3,r3 -> no stall; in X, fwd_sel_1=fwd_sel_2=01; r0 destination never forwards or stalls.
REQ-035 Interlock mode (FORWARD_EN=0, RF_BYPASS=1): add r3 then use r3 -> 2 stall cycles, fwd_sel 00; with RF_BYPASS=0 -> 3 stall cycles.
REQ-036 Redirect during load-use stall -> same cycle f_flush=1, d_flush=1, d_stall=0; next cycle X.valid=0, hazard_cnt unchanged.
REQ-037 ext_stall=1 for 5 cycles with x_redirect=1 and 3 inflight -> flushes 0, inflight stays 3, pipe frozen; on release flush asserts once.
REQ-038 Assert reset mid-stream with inflight=3, hazard_cnt=7 -> inflight=0, hazard_cnt=0 without clock edge; CNT_W=2 counts saturate at 3.
